// File: rtl/rcv_pkg.sv
// rcv_pkg: shared types and default constants for the USB receive bit timer.
//   rcv_timer_state_t : timer FSM state encoding (IDLE, ALIGN, RUN, DONE)
//   RCV_*             : default bit-timing constants
package rcv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } rcv_timer_state_t;

  localparam int RCV_CLKS_PER_BIT  = 8;
  localparam int RCV_SAMPLE_PHASE  = 3;
  localparam int RCV_BITS_PER_BYTE = 8;

endpackage

// File: rtl/rcv_bit_timer_if.sv
// rcv_bit_timer_if: signal bundle between the receive control/edge/EOP logic
// and the bit timer.
//   master : drives rcving, d_edge, eop; observes timer outputs
//   slave  : the bit timer itself
//   PW     : bit_phase width, BW : bit_count width
interface rcv_bit_timer_if
  import rcv_pkg::*;
#(
  parameter int PW = $clog2(RCV_CLKS_PER_BIT + 1),
  parameter int BW = $clog2(RCV_BITS_PER_BYTE)
) ();

  logic          rcving;
  logic          d_edge;
  logic          eop;
  logic          shift_enable;
  logic          byte_received;
  logic [PW-1:0] bit_phase;
  logic [BW-1:0] bit_count;
  logic          timer_active;
  logic          framing_err;

  modport master (
    output rcving, d_edge, eop,
    input  shift_enable, byte_received, bit_phase, bit_count,
           timer_active, framing_err
  );

  modport slave (
    input  rcving, d_edge, eop,
    output shift_enable, byte_received, bit_phase, bit_count,
           timer_active, framing_err
  );

endinterface

// File: rtl/rcv_sync_counter.sv
// rcv_sync_counter: rollover counter with synchronous active-high reset.
//   clk, rst      : clock, synchronous reset (count -> 0)
//   clear         : zero the count this cycle
//   count_enable  : advance the count; at rollover_val it wraps to START
//   rollover_val  : last value before wrapping
//   count_o       : current count
// clear and count_enable together count from zero, so the next value is
// 0 + 1; the phase counter relies on this to restart a bit at phase 1.
module rcv_sync_counter #(
  parameter int W     = 4,
  parameter int START = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         count_enable,
  input  logic [W-1:0] rollover_val,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q, count_d, base;

  always_comb begin
    base    = clear ? '0 : count_q;
    count_d = base;
    if (count_enable) begin
      count_d = (base == rollover_val) ? W'(START) : base + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: recovers USB bit timing from data-line edges.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : slave side of rcv_bit_timer_if
//     rcving/d_edge/eop in; shift_enable, byte_received, bit_phase,
//     bit_count, timer_active, framing_err out.
// Aligns on the first edge after rcving rises, restarts the phase on every
// later edge, strobes shift_enable at SAMPLE_PHASE and pulses byte_received
// the cycle after the last strobe of each byte.
module rcv_bit_timer
  import rcv_pkg::*;
#(
  parameter int CLKS_PER_BIT  = RCV_CLKS_PER_BIT,
  parameter int SAMPLE_PHASE  = RCV_SAMPLE_PHASE,
  parameter int BITS_PER_BYTE = RCV_BITS_PER_BYTE
) (
  input  logic clk,
  input  logic rst,
  rcv_bit_timer_if.slave bus
);

  localparam int PW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(BITS_PER_BYTE);

  rcv_timer_state_t state_q, state_d;
  logic             framing_err_q, framing_err_d;
  logic             byte_received_q, byte_received_d;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bits;
  logic             shift_en, in_run, stay_run;
  logic             phase_clear, bits_clear;

  assign in_run   = (state_q == RUN);
  // Mealy on rcving/eop so a drop or EOP suppresses a strobe due that cycle.
  assign shift_en = in_run && (phase == PW'(SAMPLE_PHASE)) && bus.rcving && !bus.eop;

  always_comb begin
    state_d         = state_q;
    framing_err_d   = framing_err_q;
    byte_received_d = shift_en && (bits == BW'(BITS_PER_BYTE - 1));
    case (state_q)
      IDLE: begin
        if (bus.rcving) begin
          state_d       = ALIGN;
          framing_err_d = 1'b0;
        end
      end
      ALIGN: begin
        if (!bus.rcving)                  state_d = IDLE;
        else if (!bus.eop && bus.d_edge)  state_d = RUN;
      end
      RUN: begin
        if (!bus.rcving) begin
          state_d = IDLE;
        end else if (bus.eop) begin
          state_d = DONE;
          if (bits != '0) framing_err_d = 1'b1;
        end
      end
      DONE: begin
        if (!bus.rcving) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      framing_err_q   <= 1'b0;
      byte_received_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      framing_err_q   <= framing_err_d;
      byte_received_q <= byte_received_d;
    end
  end

  // Phase restarts (clear + count -> 1) on entry to RUN and on every resync
  // edge; it drops to 0 whenever the next state is not RUN.
  assign stay_run    = (state_d == RUN);
  assign phase_clear = !in_run || bus.d_edge || !stay_run;
  assign bits_clear  = !stay_run;

  rcv_sync_counter #(.W(PW), .START(1)) u_phase_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (phase_clear),
    .count_enable (stay_run),
    .rollover_val (PW'(CLKS_PER_BIT)),
    .count_o      (phase)
  );

  rcv_sync_counter #(.W(BW), .START(0)) u_bit_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (bits_clear),
    .count_enable (shift_en),
    .rollover_val (BW'(BITS_PER_BYTE - 1)),
    .count_o      (bits)
  );

  assign bus.shift_enable  = shift_en;
  assign bus.byte_received = byte_received_q;
  assign bus.bit_phase     = phase;
  assign bus.bit_count     = bits;
  assign bus.timer_active  = (state_q == ALIGN) || (state_q == RUN);
  assign bus.framing_err   = framing_err_q;

endmodule

// File: doc/rcv_bit_timer.md
# rcv_bit_timer

Bit-timing controller for the USB receive path. It sequences the receiver's phase and bit counters to recover bit timing from the NRZI data stream. It aligns to the first SYNC edge, re-aligns on every later data edge, and emits a one-cycle `shift_enable` at the sampling point of each bit. It also pulses `byte_received` after every eighth sampled bit. It sits between the edge detector / EOP detector and the receive shift register, and is steered by the receiver control unit through `rcving`.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 8: system clocks per USB bit period.
- `SAMPLE_PHASE`, default 3: phase value (1..`CLKS_PER_BIT`) at which a bit is sampled.
- `BITS_PER_BYTE`, default 8: samples per byte.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock; reset is synchronous and active-high.
- `rcving`  in  1  receiver control unit has a packet in progress; level.
- `d_edge`  in  1  one-cycle pulse on a detected data-line transition.
- `eop`  in  1  end-of-packet detected; level.
- `shift_enable`  out  1  sample/shift strobe for the shift register.
- `byte_received`  out  1  one-cycle pulse, byte boundary.
- `bit_phase`  out  PW = $clog2(`CLKS_PER_BIT`+1)  current phase, 0 when not running.
- `bit_count`  out  BW = $clog2(`BITS_PER_BYTE`)  bits sampled in the current byte.
- `timer_active`  out  1  high in ALIGN and RUN.
- `framing_err`  out  1  sticky; EOP arrived mid-byte.

## Operation
**Reset values:** `rst`=1 at a clock edge forces state IDLE, `bit_phase`=0, `bit_count`=0, `byte_received`=0, `framing_err`=0. `timer_active`=0 and `shift_enable`=0 follow from this.

**Input priority:** `rst` > `rcving`=0 > `eop` > `d_edge` > normal counting.

States (`rcv_timer_state_t`):
- **IDLE:** phase and bit counters held cleared. `rcving`=1 → ALIGN, and `framing_err` clears on this transition.
- **ALIGN:** counters stay cleared.
  - `d_edge` → RUN, with `bit_phase`=1 on the next cycle.
  - `rcving`=0 → IDLE.
- **RUN:**
  - `bit_phase` counts 1..`CLKS_PER_BIT`, then wraps to 1.
  - `d_edge` forces next `bit_phase`=1 (resync). A `shift_enable` already due in that cycle still fires.
  - `eop`=1 → DONE. If `bit_count`≠0 in that cycle, set `framing_err`.
  - `rcving`=0 → IDLE.
- **DONE:** counters cleared, no strobes. `rcving`=0 → IDLE. `eop` or `d_edge` are ignored.

Outputs and counters:
- `shift_enable` = (state==RUN) & (`bit_phase`==`SAMPLE_PHASE`) & `rcving` & ~`eop`. This is Mealy on `rcving`/`eop` only.
- `bit_count` increments on each `shift_enable`. The shift that brings it to `BITS_PER_BYTE` instead sets it to 0 and sets `byte_received`=1 for exactly the next cycle.
- `bit_count` and `byte_received` are never modified by `d_edge`.
- Leaving RUN clears `bit_phase` and `bit_count` on the next cycle. A partial byte is discarded.

## Timing
- `d_edge` in ALIGN at cycle t:
  - `bit_phase`=1 at t+1.
  - First `shift_enable` at t+`SAMPLE_PHASE` (t+3 with defaults).
  - Subsequent strobes every `CLKS_PER_BIT` cycles absent resync.
- `byte_received` lags the final `shift_enable` of the byte by 1 cycle. With defaults it fires at t+60.
- Resync edge at phase p: the next strobe arrives `SAMPLE_PHASE` cycles after the edge cycle instead of at the nominal time.
- `eop` or `rcving` drop coincident with a due strobe suppresses that strobe.
- Mid-operation `rst` behaves like `rcving` drop plus clearing `framing_err`. There is no pending pulse after reset.
- All registered outputs change only on `clk` rising edge. There are no combinational paths from `d_edge` to outputs.

## Structure
- Package `rcv_pkg`:
  - `rcv_timer_state_t` enum {IDLE, ALIGN, RUN, DONE}.
  - Default constants `RCV_CLKS_PER_BIT`=8, `RCV_SAMPLE_PHASE`=3, `RCV_BITS_PER_BYTE`=8.
- One sub-module: `rcv_sync_counter`, a parameterised rollover counter with synchronous active-high `rst`, `clear`, `count_enable` and `rollover_val`. It is instantiated twice:
  - phase counter, with `clear` driven by resync/state exit;
  - bit counter, enabled by `shift_enable`.
- FSM, `framing_err` and `byte_received` registers live in `rcv_bit_timer`.

## Test plan
- **Reset:** reset asserted with `rcving`=1 and `d_edge` pulsing → all outputs 0, state IDLE throughout. After release with `rcving`=1 → ALIGN, `timer_active`=1 next cycle.
- **Nominal byte:** `d_edge` at t in ALIGN, no further edges → `shift_enable` at t+3, t+11, …, t+59; `byte_received` at t+60 only; `bit_count` back to 0 at t+60.
- **Resync:** in RUN, `d_edge` when `bit_phase`=6 → `bit_phase`=1 next cycle; next `shift_enable` 3 cycles after the edge; `bit_count` unchanged.
- **Framing error:** `eop` asserted when `bit_count`=5 → DONE next cycle, `framing_err`=1 and held. It stays 1 after `rcving` drop and clears on the next `rcving` rise.
- **Clean EOP:** `eop` when `bit_count`=0 → `framing_err` stays 0. An `eop` coincident with a due strobe → no `shift_enable` that cycle.
- **Abort:** `rcving` drops on the cycle of the 8th strobe → no strobe, no `byte_received`; IDLE with counters 0 next cycle.
